stepper_move_ctrl: RTL and testbench

Move sequencer for one stepper driver channel. Accepts move commands (step count, direction, step period) over a valid/ready handshake. Drives the driver's STEP/DIR/ENABLE pins with guaranteed direction-setup time and minimum pulse width. Reports busy, completion and abort status. Sits between the motion command source (host/control FSM) and the GPIO pins that feed the motor driver.

---
 rtl/stepper_move_ctrl_pkg.sv | 32 +++
 rtl/stepper_move_ctrl_if.sv | 21 ++
 rtl/stepper_move_ctrl_timer.sv | 36 +++
 rtl/stepper_move_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_stepper_move_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_move_ctrl_pkg.sv
// Shared definitions for the stepper move sequencer.
// Contents: FSM state encoding, default timing constants for a 50 MHz clock,
// the minimum STEP period constant and the period clamp helper.
package stepper_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE_HI = 3'd2,
    ST_PULSE_LO = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Default widths and timing (50 MHz clock)
  localparam int DEF_STEPS_W       = 16;
  localparam int DEF_PER_W         = 32;
  localparam int DEF_PULSE_W_CYC   = 100;  // 2 us STEP high time
  localparam int DEF_DIR_SETUP_CYC = 250;  // 5 us DIR setup before first STEP
  localparam int DEF_POS_W         = 32;

  // A STEP period shorter than twice the high time would leave a low phase
  // shorter than the driver's minimum, so periods are clamped up to this.
  localparam int MIN_PERIOD = 2 * DEF_PULSE_W_CYC;

  // Returns max(period, min_period)
  function automatic logic [63:0] clamp_period(input logic [63:0] period,
                                               input logic [63:0] min_period);
    return (period < min_period) ? min_period : period;
  endfunction

endpackage

// File: rtl/stepper_move_ctrl_if.sv
// Move command handshake between the command source and the sequencer.
// Signals: cmd_valid/cmd_ready handshake, cmd_steps (step count),
// cmd_dir (1 = forward), cmd_period (rising-to-rising STEP period, cycles).
// master = command source, slave = sequencer.
interface stepper_move_ctrl_if
  import stepper_pkg::*;
#(
  parameter int STEPS_W = DEF_STEPS_W,
  parameter int PER_W   = DEF_PER_W
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [STEPS_W-1:0] cmd_steps;
  logic               cmd_dir;
  logic [PER_W-1:0]   cmd_period;

  modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_period,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_steps, cmd_dir, cmd_period,
                  output cmd_ready);
endinterface

// File: rtl/stepper_move_ctrl_timer.sv
// step_timer: loadable down-counter timing the SETUP, PULSE_HI and PULSE_LO
// intervals. Ports: clk, reset (sync, active high), load/load_val (reload),
// expire (high during the last cycle of a loaded interval of load_val cycles).
module step_timer
  import stepper_pkg::*;
#(
  parameter int PER_W = DEF_PER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PER_W-1:0] load_val,
  output logic             expire
);
  logic [PER_W-1:0] cnt_q, cnt_d;

  // Next count: reload, else count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PER_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == PER_W'(1'b1));
endmodule

// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl: move sequencer for one stepper driver channel.
// Ports: clk, reset (sync, active high); cmd (stepper_move_ctrl_if.slave)
// carrying move commands; abort (end move early); step_out/dir_out/enable_out
// driver pins; busy, done (1-cycle pulse), aborted (valid with done),
// steps_done (pulses issued in current/last move).
// Optional build macro STEP_POS_TRACK_EN adds pos_clear input and signed
// position output (parameter POS_W).
// All outputs are registered, decoded from the next FSM state.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int STEPS_W       = DEF_STEPS_W,
  parameter int PER_W         = DEF_PER_W,
  parameter int PULSE_W_CYC   = DEF_PULSE_W_CYC,
  parameter int DIR_SETUP_CYC = DEF_DIR_SETUP_CYC
`ifdef STEP_POS_TRACK_EN
  , parameter int POS_W       = DEF_POS_W
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  stepper_move_ctrl_if.slave       cmd,
  input  logic                     abort,
`ifdef STEP_POS_TRACK_EN
  input  logic                     pos_clear,
  output logic signed [POS_W-1:0]  position,
`endif
  output logic                     step_out,
  output logic                     dir_out,
  output logic                     enable_out,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [STEPS_W-1:0]       steps_done
);
  state_e             state_q, state_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [PER_W-1:0]   eff_period_q, eff_period_d;
  logic               abort_pend_q, abort_pend_d;
  logic               dir_out_q, dir_out_d;
  logic [STEPS_W-1:0] steps_done_q, steps_done_d;
  logic               aborted_q, aborted_d;
  logic               step_out_q, step_out_d;
  logic               enable_out_q, enable_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cmd_ready_q, cmd_ready_d;

  logic               tmr_load;
  logic [PER_W-1:0]   tmr_val;
  logic               tmr_expire;
  logic               hi_exit;

  step_timer #(.PER_W(PER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign hi_exit = (state_q == ST_PULSE_HI) && tmr_expire;

  // Next-state, move bookkeeping and registered-output decode
  always_comb begin
    state_d      = state_q;
    steps_d      = steps_q;
    eff_period_d = eff_period_q;
    abort_pend_d = abort_pend_q;
    dir_out_d    = dir_out_q;
    steps_done_d = steps_done_q;
    aborted_d    = aborted_q;

    case (state_q)
      ST_IDLE: begin
        // abort is ignored here, including when it coincides with a command
        if (cmd.cmd_valid && cmd_ready_q) begin
          steps_d      = cmd.cmd_steps;
          dir_out_d    = cmd.cmd_dir;
          eff_period_d = PER_W'(clamp_period(64'(cmd.cmd_period),
                                             64'(2 * PULSE_W_CYC)));
          steps_done_d = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = (cmd.cmd_steps == '0) ? ST_DONE : ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (tmr_expire) begin
          state_d = ST_PULSE_HI;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_PULSE_HI: begin
        // An abort during the pulse is remembered; the pulse runs full width
        if (abort) begin
          abort_pend_d = 1'b1;
        end else begin
          abort_pend_d = abort_pend_q;
        end
        if (tmr_expire) begin
          steps_done_d = steps_done_q + STEPS_W'(1'b1);
          if (abort_pend_q || abort) begin
            aborted_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_PULSE_LO;
          end
        end else begin
          state_d = ST_PULSE_HI;
        end
      end
      ST_PULSE_LO: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (tmr_expire) begin
          state_d = (steps_done_q == steps_q) ? ST_DONE : ST_PULSE_HI;
        end else begin
          state_d = ST_PULSE_LO;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The single timer is reloaded on every state change with the length
    // of the state being entered; untimed states load zero.
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_SETUP:    tmr_val = PER_W'(DIR_SETUP_CYC);
      ST_PULSE_HI: tmr_val = PER_W'(PULSE_W_CYC);
      ST_PULSE_LO: tmr_val = eff_period_q - PER_W'(PULSE_W_CYC);
      default:     tmr_val = '0;
    endcase

    step_out_d   = (state_d == ST_PULSE_HI);
    enable_out_d = (state_d == ST_SETUP) || (state_d == ST_PULSE_HI) ||
                   (state_d == ST_PULSE_LO);
    busy_d       = enable_out_d || (state_d == ST_DONE);
    done_d       = (state_d == ST_DONE);
    cmd_ready_d  = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      steps_q      <= '0;
      eff_period_q <= '0;
      abort_pend_q <= 1'b0;
      dir_out_q    <= 1'b0;
      steps_done_q <= '0;
      aborted_q    <= 1'b0;
      step_out_q   <= 1'b0;
      enable_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      steps_q      <= steps_d;
      eff_period_q <= eff_period_d;
      abort_pend_q <= abort_pend_d;
      dir_out_q    <= dir_out_d;
      steps_done_q <= steps_done_d;
      aborted_q    <= aborted_d;
      step_out_q   <= step_out_d;
      enable_out_q <= enable_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign step_out      = step_out_q;
  assign dir_out       = dir_out_q;
  assign enable_out    = enable_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign steps_done    = steps_done_q;

`ifdef STEP_POS_TRACK_EN
  logic signed [POS_W-1:0] position_q, position_d;

  // Position follows each completed pulse; clear wins over a coincident step
  always_comb begin
    position_d = position_q;
    if (pos_clear) begin
      position_d = '0;
    end else if (hi_exit) begin
      position_d = dir_out_q ? (position_q + POS_W'(1'b1))
                             : (position_q - POS_W'(1'b1));
    end else begin
      position_d = position_q;
    end
  end

  // Position register
  always_ff @(posedge clk) begin
    if (reset) position_q <= '0;
    else       position_q <= position_d;
  end

  assign position = position_q;
`endif

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Self-checking bench for stepper_move_ctrl with PULSE_W_CYC=2, DIR_SETUP_CYC=3.
// Expected STEP rising-edge cycles and done records are queued when a command
// is issued and compared by a monitor as the DUT produces them.
module tb_stepper_move_ctrl;
  localparam int PW = 2;
  localparam int SU = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        abort = 1'b0;
  logic        step_out, dir_out, enable_out, busy, done, aborted;
  logic [15:0] steps_done;
`ifdef STEP_POS_TRACK_EN
  logic        pos_clear = 1'b0;
  logic signed [31:0] position;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hi_len = 0;
  logic step_prev = 1'b0;
  bit trunc_ok = 1'b0;
  int rdy_busy = 0;

  int rise_q[$];
  int dn_cyc_q[$];
  int dn_steps_q[$];
  int dn_ab_q[$];

  stepper_move_ctrl_if #(.STEPS_W(16), .PER_W(32)) cmd_if ();

  stepper_move_ctrl #(
    .STEPS_W(16), .PER_W(32), .PULSE_W_CYC(PW), .DIR_SETUP_CYC(SU)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .abort      (abort),
`ifdef STEP_POS_TRACK_EN
    .pos_clear  (pos_clear),
    .position   (position),
`endif
    .step_out   (step_out),
    .dir_out    (dir_out),
    .enable_out (enable_out),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps_done (steps_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: STEP edges, pulse width, done records, ready-while-busy
  always @(negedge clk) begin
    if (busy && cmd_if.cmd_ready) rdy_busy <= rdy_busy + 1;
    if (step_out && !step_prev) begin
      hi_len <= 1;
      if (rise_q.size() == 0) check_eq("rise_unexp", rise_q.size(), 1);
      else check_eq("rise_cyc", cyc, rise_q.pop_front());
    end else if (step_out) begin
      hi_len <= hi_len + 1;
    end else if (step_prev && !trunc_ok) begin
      check_eq("pulse_w", hi_len, PW);
    end
    if (done) begin
      if (dn_cyc_q.size() == 0) begin
        check_eq("done_unexp", dn_cyc_q.size(), 1);
      end else begin
        check_eq("done_cyc", cyc, dn_cyc_q.pop_front());
        check_eq("steps_done", steps_done, dn_steps_q.pop_front());
        check_eq("aborted", aborted, dn_ab_q.pop_front());
      end
    end
    step_prev <= step_out;
  end

  // Issue a command (called at a negedge); queue its expected outcome.
  // ab_pulse > 0 means the bench will abort during that pulse.
  task automatic issue(input logic [15:0] s, input logic d, input logic [31:0] p,
                       input int ab_pulse, input bit keep, output int acc);
    int eff, n, budget;
    cmd_if.cmd_steps  = s;
    cmd_if.cmd_dir    = d;
    cmd_if.cmd_period = p;
    cmd_if.cmd_valid  = 1'b1;
    budget = 0;
    while (cmd_if.cmd_ready !== 1'b1 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    check_eq("accept_wait", cmd_if.cmd_ready, 1);
    acc = cyc + 1;
    eff = (p < 32'(2 * PW)) ? 2 * PW : int'(p);
    n   = (ab_pulse > 0) ? ab_pulse : int'(s);
    for (int k = 0; k < n; k++) rise_q.push_back(acc + SU + k * eff);
    if (s == 16'd0)       dn_cyc_q.push_back(acc);
    else if (ab_pulse > 0) dn_cyc_q.push_back(acc + SU + (n - 1) * eff + PW);
    else                   dn_cyc_q.push_back(acc + SU + n * eff);
    dn_steps_q.push_back(n);
    dn_ab_q.push_back((ab_pulse > 0) ? 1 : 0);
    @(negedge clk);
    if (!keep) cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (dn_cyc_q.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    check_eq("done_tmo", dn_cyc_q.size(), 0);
    check_eq("rise_left", rise_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc, a1, a2;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_steps  = 16'd0;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_period = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", cmd_if.cmd_ready, 1);
    check_eq("rst_step", step_out, 0);
    check_eq("rst_dir", dir_out, 0);
    check_eq("rst_en", enable_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_abrt", aborted, 0);
    check_eq("rst_sdone", steps_done, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1. nominal move
    issue(16'd3, 1'b1, 32'd10, 0, 1'b0, acc);
    check_eq("t1_dir", dir_out, 1);
    check_eq("t1_en", enable_out, 1);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_ready", cmd_if.cmd_ready, 0);
    wait_done();
    check_eq("t1_en_off", enable_out, 0);

    // 2. zero steps
    issue(16'd0, 1'b0, 32'd10, 0, 1'b0, acc);
    check_eq("t2_busy1", busy, 1);
    @(negedge clk);
    check_eq("t2_busy0", busy, 0);
    wait_done();

    // 3. period clamp; abort coinciding with the accept is ignored
    abort = 1'b1;
    issue(16'd2, 1'b1, 32'd1, 0, 1'b0, acc);
    abort = 1'b0;
    wait_done();

    // 4. abort during the 2nd pulse
    issue(16'd5, 1'b1, 32'd10, 2, 1'b0, acc);
    repeat (13) @(negedge clk);
    check_eq("t4_inpulse", step_out, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done();

    // 5. reset mid-pulse
    issue(16'd3, 1'b1, 32'd10, 0, 1'b0, acc);
    repeat (4) @(negedge clk);
    check_eq("t5_inpulse", step_out, 1);
    trunc_ok = 1'b1;
    rise_q.delete();
    dn_cyc_q.delete();
    dn_steps_q.delete();
    dn_ab_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_step", step_out, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_en", enable_out, 0);
    check_eq("t5_ready", cmd_if.cmd_ready, 1);
    check_eq("t5_sdone", steps_done, 0);
`ifdef STEP_POS_TRACK_EN
    check_eq("t5_pos", position, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    trunc_ok = 1'b0;
    @(negedge clk);

    // 6. back-to-back commands with cmd_valid held high
    rdy_busy = 0;
    issue(16'd3, 1'b1, 32'd4, 0, 1'b1, a1);
    issue(16'd2, 1'b0, 32'd4, 0, 1'b0, a2);
    check_eq("t6_b2b", a2, a1 + SU + 3 * 2 * PW + 2);
    check_eq("t6_dir", dir_out, 0);
    wait_done();
    check_eq("t6_rdybusy", rdy_busy, 0);
`ifdef STEP_POS_TRACK_EN
    check_eq("t6_pos", position, 1);
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
    check_eq("t6_posclr", position, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
